uart_tx_packet_loader: RTL

Framing stage directly upstream of the transmit FIFO in the UART path. Accepts a payload from a host byte stream and writes a complete frame into the FIFO over its LOAD_FIFO / LD_FIFO_DONE handshake. The frame is SOF, length, payload bytes, then a checksum. The UART transmitter serialises the frame after the FIFO is loaded.

---
 rtl/uart_tx_packet_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_packet_loader.sv
// Frames a host payload as SOF, LEN, payload, checksum and writes it into the TX FIFO over a 4-phase handshake.
// Optional UART_PKT_CRC8_EN selects CRC-8 (poly 0x07) instead of the XOR checksum.
//
// state   | meaning
// IDLE    | waiting for START
// SEL     | pick the next frame byte for the current phase
// GET     | wait for a host payload byte
// WRITE   | LOAD_FIFO high until LD_FIFO_DONE high
// RELEASE | LOAD_FIFO low until LD_FIFO_DONE low
// DONE    | one-cycle PKT_DONE, back to IDLE
module uart_tx_packet_loader #(
  parameter int          MAX_LEN = 16,
  parameter logic [7:0]  SOF     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] host_data,
  input  logic       host_valid,
  output logic       host_ready,
  output logic       load_fifo,
  output logic [7:0] data_in_fifo,
  input  logic       ld_fifo_done,
  output logic       busy,
  output logic       pkt_done,
  output logic       len_err
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_GET, S_WRITE, S_RELEASE, S_DONE} state_t;
  typedef enum logic [2:0] {PH_SOF, PH_LEN, PH_PAY, PH_CSUM, PH_END} phase_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [7:0] len_q, cnt_q, csum_q, data_q;
  logic       len_err_q;
  logic       len_ok;

  function automatic logic [7:0] csum_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
`ifdef UART_PKT_CRC8_EN
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
`endif
    return r;
  endfunction

  assign len_ok = (len != 8'd0) && (len <= MAX_LEN_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= PH_SOF;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        if (start && len_ok) begin
          state_d = S_SEL;
          phase_d = PH_SOF;
        end
      end
      S_SEL: begin
        case (phase_q)
          PH_PAY:  state_d = S_GET;
          PH_END:  state_d = S_DONE;
          default: state_d = S_WRITE;
        endcase
      end
      S_GET:     if (host_valid) state_d = S_WRITE;
      S_WRITE:   if (ld_fifo_done) state_d = S_RELEASE;
      S_RELEASE: begin
        if (!ld_fifo_done) begin
          state_d = S_SEL;
          case (phase_q)
            PH_SOF:  phase_d = PH_LEN;
            PH_LEN:  phase_d = PH_PAY;
            PH_PAY:  phase_d = (cnt_q == len_q) ? PH_CSUM : PH_PAY;
            PH_CSUM: phase_d = PH_END;
            default: phase_d = PH_END;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers only move in IDLE/SEL/GET, so DATA_IN_FIFO is frozen across WRITE/RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= 8'h00;
      cnt_q     <= 8'h00;
      csum_q    <= 8'h00;
      data_q    <= 8'h00;
      len_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_err_q <= 1'b0;
              len_q     <= len;
              csum_q    <= 8'h00;
              cnt_q     <= 8'h00;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        S_SEL: begin
          case (phase_q)
            PH_SOF:  data_q <= SOF;
            PH_LEN: begin
              data_q <= len_q;
              csum_q <= csum_step(csum_q, len_q);
            end
            PH_CSUM: data_q <= csum_q;
            default: ;
          endcase
        end
        S_GET: begin
          if (host_valid) begin
            data_q <= host_data;
            csum_q <= csum_step(csum_q, host_data);
            cnt_q  <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign host_ready   = (state_q == S_GET);
  assign load_fifo    = (state_q == S_WRITE);
  assign data_in_fifo = data_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign pkt_done     = (state_q == S_DONE);
  assign len_err      = len_err_q;

endmodule
